page_alloc_arbiter: RTL and testbench
=====================================

PAGE_ALLOC_ARBITER -- requirements
Module: page_alloc_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of allocation ports and number of release ports.
REQ-002 Parameter ADDR_W, default 11, page address width.
REQ-003 Parameter PAGE_COUNT, default 2048, total pages managed by the free-page FIFO.
REQ-004 Parameter LOW_WM, default 16, free-count threshold for the low-watermark output.
REQ-005 clk  input  1  clock; all state SHALL be rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 alloc_req  input  NUM_PORTS  per-port page request, level, held until granted.
REQ-008 alloc_gnt  output  NUM_PORTS  registered one-hot grant, one cycle wide.
REQ-009 alloc_addr  output  ADDR_W  registered page address, valid while any alloc_gnt bit is high.
REQ-010 rel_req  input  NUM_PORTS  per-port page-release request, level.
REQ-011 rel_addr  input  NUM_PORTS*ADDR_W  packed release addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 rel_ack  output  NUM_PORTS  combinational one-hot release acceptance, same cycle as the push.
REQ-013 pop_head  output  1  combinational pop strobe to the free-page FIFO.
REQ-014 head_addr  input  ADDR_W  current free-page FIFO head.
REQ-015 push_tail  output  1  combinational push strobe to the free-page FIFO.
REQ-016 tail_addr  output  ADDR_W  combinational address pushed to the free-page FIFO.
REQ-017 free_cnt  output  ADDR_W+1  registered count of free pages.
REQ-018 low_wm  output  1  registered, high when free_cnt <= LOW_WM.
REQ-019 err_ovf  output  1  sticky, registered release-overflow error.

Function
REQ-020 Allocation arbiter SHALL be round-robin, one grant per cycle; search starts at port alloc_ptr+1 modulo NUM_PORTS.
REQ-021 In cycle T with any alloc_req and free_cnt != 0: pop_head=1, winner w selected, alloc_addr<=head_addr, alloc_gnt<=one-hot(w), alloc_ptr<=w.
REQ-022 Grant latency SHALL be exactly 1 cycle: request seen in T, alloc_gnt/alloc_addr visible in T+1.
REQ-023 A port whose alloc_gnt is high in the current cycle SHALL be masked from arbitration in that cycle; the grant is taken as consumption of the page.
REQ-024 With free_cnt == 0, no grant and pop_head=0, even if a release is accepted the same cycle; no bypass path.
REQ-025 Release arbiter SHALL be round-robin with independent pointer rel_ptr, one release per cycle.
REQ-026 In cycle T with any rel_req and free_cnt < PAGE_COUNT: push_tail=1, tail_addr=rel_addr of winner r, rel_ack[r]=1, rel_ptr<=r.
REQ-027 Release with free_cnt == PAGE_COUNT (net of same-cycle pop) SHALL be acked and dropped: push_tail=0, err_ovf<=1.
REQ-028 free_cnt update: +1 on push only, -1 on pop only, unchanged on both or neither; no wrap.
REQ-029 low_wm SHALL be computed from the next-state free_cnt.
REQ-030 Allocation and release SHALL proceed independently in the same cycle.
REQ-031 alloc_gnt, pop_head, push_tail, rel_ack SHALL each be zero or one-hot.

Reset
REQ-032 On rst_n low: alloc_gnt=0, alloc_addr=0, free_cnt=PAGE_COUNT, low_wm=0, err_ovf=0, alloc_ptr=NUM_PORTS-1, rel_ptr=NUM_PORTS-1.
REQ-033 Combinational outputs SHALL be 0 while rst_n is low.
REQ-034 Reset mid-operation SHALL abort any pending grant; no alloc_gnt SHALL appear in the cycle after rst_n deasserts.

Verification
REQ-035 After reset, alloc_req=4'b0001 one cycle, head_addr=0 -> pop_head=1 in T; alloc_gnt=0001, alloc_addr=0 in T+1; free_cnt=2047.
REQ-036 alloc_req=4'b1111 held 8 cycles after reset -> grants in order ports 0,1,2,3,0,1,2,3; free_cnt=2040.
REQ-037 Drain to free_cnt=0, hold alloc_req=0001 -> no grants; rel_req=0100, rel_addr[2]=5 -> rel_ack=0100, push_tail=1, tail_addr=5, free_cnt=1, grant next cycle.
REQ-038 Same-cycle alloc and release at free_cnt=100 -> pop_head=1, push_tail=1, free_cnt stays 100.
REQ-039 Release with free_cnt=2048 -> rel_ack=1, push_tail=0, err_ovf=1 until reset.
REQ-040 Allocate down to free_cnt=16 -> low_wm=1 in the same cycle that free_cnt=16; one release -> low_wm=0.

Source files
------------

// File: rtl/page_alloc_arbiter.sv
// rtl/page_alloc_arbiter.sv - round-robin page allocate/release arbiter for a free-page FIFO
module page_alloc_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 11,
  parameter int PAGE_COUNT = 2048,
  parameter int LOW_WM     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        alloc_req,
  output logic [NUM_PORTS-1:0]        alloc_gnt,
  output logic [ADDR_W-1:0]           alloc_addr,
  input  logic [NUM_PORTS-1:0]        rel_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] rel_addr,
  output logic [NUM_PORTS-1:0]        rel_ack,
  output logic                        pop_head,
  input  logic [ADDR_W-1:0]           head_addr,
  output logic                        push_tail,
  output logic [ADDR_W-1:0]           tail_addr,
  output logic [ADDR_W:0]             free_cnt,
  output logic                        low_wm,
  output logic                        err_ovf
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(PAGE_COUNT);
  localparam logic [ADDR_W:0] WM = (ADDR_W+1)'(LOW_WM);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_PORTS - 1);

  logic [PTR_W-1:0]     alloc_ptr, rel_ptr, alloc_win, rel_win;
  logic                 alloc_any, rel_any, rel_drop;
  logic [NUM_PORTS-1:0] alloc_elig;
  logic [ADDR_W:0]      free_nxt;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int off);
    int s;
    s = (int'(ptr) + off) % NUM_PORTS;
    return PTR_W'(s);
  endfunction

  // A port holding a grant this cycle has already consumed its page.
  assign alloc_elig = alloc_req & ~alloc_gnt;

  always_comb begin
    alloc_any = 1'b0;
    alloc_win = '0;
    rel_any   = 1'b0;
    rel_win   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!alloc_any && alloc_elig[rr_idx(alloc_ptr, i)]) begin
        alloc_any = 1'b1;
        alloc_win = rr_idx(alloc_ptr, i);
      end
      if (!rel_any && rel_req[rr_idx(rel_ptr, i)]) begin
        rel_any = 1'b1;
        rel_win = rr_idx(rel_ptr, i);
      end
    end
  end

  always_comb begin
    pop_head  = rst_n && alloc_any && (free_cnt != '0);
    // Overflow is judged after the same-cycle pop has made room.
    rel_drop  = (free_cnt == FULL) && !pop_head;
    push_tail = rst_n && rel_any && !rel_drop;
    rel_ack   = '0;
    tail_addr = '0;
    if (rst_n && rel_any)
      rel_ack[rel_win] = 1'b1;
    if (push_tail)
      tail_addr = rel_addr[int'(rel_win)*ADDR_W +: ADDR_W];
    free_nxt = free_cnt;
    if (push_tail && !pop_head)
      free_nxt = free_cnt + 1'b1;
    else if (pop_head && !push_tail)
      free_nxt = free_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_gnt  <= '0;
      alloc_addr <= '0;
      alloc_ptr  <= LAST;
      rel_ptr    <= LAST;
      free_cnt   <= FULL;
      low_wm     <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      alloc_gnt <= '0;
      if (pop_head) begin
        alloc_gnt[alloc_win] <= 1'b1;
        alloc_addr           <= head_addr;
        alloc_ptr            <= alloc_win;
      end
      if (rel_any)
        rel_ptr <= rel_win;
      free_cnt <= free_nxt;
      low_wm   <= (free_nxt <= WM);
      if (rel_any && rel_drop)
        err_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_page_alloc_arbiter.sv
// tb/tb_page_alloc_arbiter.sv - randomized bench with behavioural model for page_alloc_arbiter
module tb_page_alloc_arbiter;
  localparam int NP = 4;
  localparam int AW = 11;
  localparam int PC = 2048;
  localparam int WMK = 16;

  logic          clk, rst_n;
  logic [NP-1:0] alloc_req, alloc_gnt, rel_req, rel_ack;
  logic [AW-1:0] alloc_addr, head_addr, tail_addr;
  logic [NP*AW-1:0] rel_addr;
  logic          pop_head, push_tail, low_wm, err_ovf;
  logic [AW:0]   free_cnt;

  page_alloc_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .PAGE_COUNT(PC), .LOW_WM(WMK)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_addr(alloc_addr), .rel_req(rel_req), .rel_addr(rel_addr), .rel_ack(rel_ack),
    .pop_head(pop_head), .head_addr(head_addr), .push_tail(push_tail), .tail_addr(tail_addr),
    .free_cnt(free_cnt), .low_wm(low_wm), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  int m_free, m_aptr, m_rptr, m_gnt_port, m_addr;
  bit m_ovf;

  // values observed on the most recent step, for literal checks
  logic [NP-1:0] obs_rel_ack;
  logic          obs_pop, obs_push;
  logic [AW-1:0] obs_tail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_free = PC; m_aptr = NP - 1; m_rptr = NP - 1;
    m_gnt_port = -1; m_addr = 0; m_ovf = 0;
  endtask

  // Enter at posedge+1; drive, compare mid-cycle, advance model at the edge.
  task automatic step(input logic [NP-1:0] req, input logic [NP-1:0] rreq, input logic [NP*AW-1:0] raddr);
    int w, r, p;
    bit pop, push;
    logic [NP-1:0] exp_ack;
    logic [AW-1:0] head;
    head = AW'($urandom);
    alloc_req = req; rel_req = rreq; rel_addr = raddr; head_addr = head;
    @(negedge clk);
    w = -1; r = -1;
    for (int k = 1; k <= NP; k++) begin
      p = (m_aptr + k) % NP;
      if (w < 0 && req[p] && p != m_gnt_port) w = p;
      p = (m_rptr + k) % NP;
      if (r < 0 && rreq[p]) r = p;
    end
    pop  = (w >= 0) && (m_free > 0);
    push = (r >= 0) && ((m_free - int'(pop)) < PC);
    exp_ack = (r >= 0) ? NP'(1 << r) : '0;
    chk("alloc_gnt", 32'(alloc_gnt), (m_gnt_port >= 0) ? 32'(1 << m_gnt_port) : 32'd0);
    if (m_gnt_port >= 0) chk("alloc_addr", 32'(alloc_addr), 32'(m_addr));
    chk("free_cnt", 32'(free_cnt), 32'(m_free));
    chk("low_wm", 32'(low_wm), 32'(m_free <= WMK));
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("pop_head", 32'(pop_head), 32'(pop));
    chk("push_tail", 32'(push_tail), 32'(push));
    chk("rel_ack", 32'(rel_ack), 32'(exp_ack));
    if (push) chk("tail_addr", 32'(tail_addr), 32'(raddr[r*AW +: AW]));
    obs_rel_ack = rel_ack; obs_pop = pop_head; obs_push = push_tail; obs_tail = tail_addr;
    @(posedge clk);
    if (pop) begin m_gnt_port = w; m_addr = int'(head); m_aptr = w; end
    else m_gnt_port = -1;
    if (r >= 0) m_rptr = r;
    if ((r >= 0) && !push) m_ovf = 1;
    m_free = m_free + int'(push) - int'(pop);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_req = NP'($urandom); rel_req = NP'($urandom);
    rel_addr = {$urandom, $urandom}; head_addr = AW'($urandom);
    @(negedge clk);
    chk("rst alloc_gnt", 32'(alloc_gnt), 0);
    chk("rst alloc_addr", 32'(alloc_addr), 0);
    chk("rst free_cnt", 32'(free_cnt), PC);
    chk("rst low_wm", 32'(low_wm), 0);
    chk("rst err_ovf", 32'(err_ovf), 0);
    chk("rst comb", {pop_head, push_tail, rel_ack, tail_addr}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_phase(input int n, input int p_alloc, input int p_rel);
    logic [NP-1:0] rq, rr;
    for (int c = 0; c < n; c++) begin
      for (int b = 0; b < NP; b++) begin
        rq[b] = ($urandom_range(99) < p_alloc);
        rr[b] = ($urandom_range(99) < p_rel);
      end
      if ($urandom_range(999) == 0) do_reset();
      else step(rq, rr, {$urandom, $urandom});
    end
  endtask

  logic [NP*AW-1:0] ra;
  logic [NP-1:0] order[$];
  logic [NP-1:0] exp_order[8];

  initial begin
    rst_n = 1'b0;
    alloc_req = '0; rel_req = '0; rel_addr = '0; head_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single request, head 0
    alloc_req = 4'b0001; rel_req = '0; head_addr = '0;
    @(negedge clk);
    chk("t35 pop", 32'(pop_head), 1);
    @(posedge clk); #1;
    m_gnt_port = 0; m_addr = 0; m_aptr = 0; m_free = PC - 1;
    chk("t35 gnt", 32'(alloc_gnt), 32'b0001);
    chk("t35 addr", 32'(alloc_addr), 0);
    chk("t35 free", 32'(free_cnt), 2047);

    // all ports for 8 cycles
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, '0, '0);
      order.push_back(alloc_gnt);
    end
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) chk("t36 order", 32'(order[i]), 32'(exp_order[i]));
    chk("t36 free", 32'(free_cnt), 2040);

    // drain to zero, then release unblocks one grant
    do_reset();
    repeat (PC) step(4'b1111, '0, '0);
    chk("t37 empty", 32'(free_cnt), 0);
    chk("t37 low_wm", 32'(low_wm), 1);
    step(4'b0001, '0, '0);
    chk("t37 no pop", 32'(obs_pop), 0);
    ra = '0; ra[2*AW +: AW] = 11'd5;
    step(4'b0001, 4'b0100, ra);
    chk("t37 no pop rel", 32'(obs_pop), 0);
    chk("t37 ack", 32'(obs_rel_ack), 32'b0100);
    chk("t37 push", 32'(obs_push), 1);
    chk("t37 tail", 32'(obs_tail), 5);
    chk("t37 free1", 32'(free_cnt), 1);
    chk("t37 no gnt", 32'(alloc_gnt), 0);
    step(4'b0001, '0, '0);
    chk("t37 pop", 32'(obs_pop), 1);
    chk("t37 gnt", 32'(alloc_gnt), 32'b0001);
    rand_phase(1500, 40, 40);

    // simultaneous alloc and release at 100 free
    do_reset();
    repeat (PC - 100) step(4'b1111, '0, '0);
    chk("t38 at100", 32'(free_cnt), 100);
    step(4'b0001, 4'b0001, {$urandom, $urandom});
    chk("t38 pop", 32'(obs_pop), 1);
    chk("t38 push", 32'(obs_push), 1);
    chk("t38 free", 32'(free_cnt), 100);

    // overflow when full
    do_reset();
    step('0, 4'b0010, {$urandom, $urandom});
    chk("t39 ack", 32'(obs_rel_ack), 32'b0010);
    chk("t39 push", 32'(obs_push), 0);
    chk("t39 ovf", 32'(err_ovf), 1);
    repeat (5) step(4'b0011, '0, '0);
    chk("t39 sticky", 32'(err_ovf), 1);

    // low watermark edge
    do_reset();
    repeat (PC - 17) step(4'b1111, '0, '0);
    chk("t40 f17", 32'(free_cnt), 17);
    chk("t40 low17", 32'(low_wm), 0);
    step(4'b1111, '0, '0);
    chk("t40 f16", 32'(free_cnt), 16);
    chk("t40 low16", 32'(low_wm), 1);
    step('0, 4'b1000, {$urandom, $urandom});
    chk("t40 rel", 32'(low_wm), 0);

    do_reset();
    rand_phase(1500, 35, 15);
    rand_phase(1000, 20, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
